// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter generator.
//   pc_state_e  : fetch sequencing state (BOOT, RUN, HALTED)
//   align_mask  : address mask that clears the low log2(inc) bits
// Optional feature macro used by pc_gen: PC_MISALIGN_CHECK_EN.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  // inc is a power of two, so inc-1 is exactly the set of low bits to clear.
  function automatic logic [63:0] align_mask(input int unsigned inc);
    return ~(64'(inc) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// XLEN-wide PC holding register.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset, loads RESET_VECTOR
//   i_load  : load enable
//   i_d     : next PC value
//   o_q     : current PC value
module pc_reg #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_d,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= RESET_VECTOR;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: owns the current PC and
// picks the next one (increment, stall, branch redirect, trap redirect,
// halt/resume, one boot cycle after reset).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   stall               : hold PC this cycle
//   br_taken, br_target : branch/jump redirect
//   trap, trap_vector   : trap redirect (highest priority)
//   halt, resume        : stop / restart fetch
//   pc_out, pc_valid    : current PC and fetch-valid qualifier (registered)
//   pc_seq              : pc_out + INC, link address
//   misalign, misalign_addr : misaligned-branch report
// Macro PC_MISALIGN_CHECK_EN: when defined, a misaligned branch target
// diverts to the trap vector and is reported on misalign/misalign_addr;
// otherwise targets are silently aligned and the report outputs are 0.
//
// state  | meaning
// BOOT   | first cycle after reset, PC held, requests ignored
// RUN    | fetching, pc_valid=1
// HALTED | fetch stopped, only trap or resume leave
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_seq,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  localparam logic [63:0]     MASK64     = align_mask(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = MASK64[XLEN-1:0];
  localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);

  pc_state_e       r_state;
  pc_state_e       w_state_next;
  logic            r_pc_valid;
  logic            w_pc_load;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_trap_al;
  logic [XLEN-1:0] w_br_al;

  assign w_trap_al = trap_vector & ALIGN_MASK;
  assign w_br_al   = br_target & ALIGN_MASK;

`ifdef PC_MISALIGN_CHECK_EN
  logic            w_br_mis;
  logic            w_mis_set;
  logic            r_misalign;
  logic [XLEN-1:0] r_misalign_addr;
  assign w_br_mis = |(br_target & ~ALIGN_MASK);
`endif

  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_pc_next    = w_pc;
`ifdef PC_MISALIGN_CHECK_EN
    w_mis_set    = 1'b0;
`endif
    case (r_state)
      BOOT: w_state_next = RUN;
      RUN: begin
        if (trap) begin
          w_pc_load = 1'b1;
          w_pc_next = w_trap_al;
        end else if (br_taken) begin
          w_pc_load = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
          if (w_br_mis) begin
            w_pc_next = w_trap_al;
            w_mis_set = 1'b1;
          end else begin
            w_pc_next = w_br_al;
          end
`else
          w_pc_next = w_br_al;
`endif
        end else if (halt) begin
          w_state_next = HALTED;
        end else if (!stall) begin
          w_pc_load = 1'b1;
          w_pc_next = w_pc + INC_X;
        end
      end
      HALTED: begin
        if (trap) begin
          w_pc_load    = 1'b1;
          w_pc_next    = w_trap_al;
          w_state_next = RUN;
        end else if (resume) begin
          w_state_next = RUN;
        end
      end
      default: w_state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc_valid <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_pc_valid <= (w_state_next == RUN);
`ifdef PC_MISALIGN_CHECK_EN
      r_misalign <= w_mis_set;
      if (w_mis_set) r_misalign_addr <= br_target;
`endif
    end
  end

  pc_reg #(
    .XLEN        (XLEN),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_pc_load),
    .i_d   (w_pc_next),
    .o_q   (w_pc)
  );

  assign pc_out   = w_pc;
  assign pc_valid = r_pc_valid;
  assign pc_seq   = w_pc + INC_X;

`ifdef PC_MISALIGN_CHECK_EN
  assign misalign      = r_misalign;
  assign misalign_addr = r_misalign_addr;
`else
  assign misalign      = 1'b0;
  assign misalign_addr = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// compared against a behavioural model of the PC sequencing rules.
// A second instance with RESET_VECTOR=0xFFFF_FFF8 covers address wrap.
module tb_pc_gen;

`ifdef PC_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        trap = 1'b0;
  logic [31:0] trap_vector = '0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;

  logic [31:0] pc_out, pc_seq, misalign_addr;
  logic        pc_valid, misalign;
  logic [31:0] pc_out2, pc_seq2, misalign_addr2;
  logic        pc_valid2, misalign2;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [31:0] m_pc;
  bit          m_booting;
  bit          m_halted;
  bit          m_mis;
  logic [31:0] m_mis_addr;

  pc_gen #(.XLEN(32), .INC(4), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .trap(trap), .trap_vector(trap_vector),
    .halt(halt), .resume(resume), .pc_out(pc_out), .pc_valid(pc_valid),
    .pc_seq(pc_seq), .misalign(misalign), .misalign_addr(misalign_addr)
  );

  pc_gen #(.XLEN(32), .INC(4), .RESET_VECTOR(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .trap(trap), .trap_vector(trap_vector),
    .halt(halt), .resume(resume), .pc_out(pc_out2), .pc_valid(pc_valid2),
    .pc_seq(pc_seq2), .misalign(misalign2), .misalign_addr(misalign_addr2)
  );

  always #5 clk = ~clk;

  // One clock of the behavioural model, using the inputs seen at the edge.
  task automatic model_step();
    if (!rst_n) begin
      m_pc = 32'h0; m_booting = 1; m_halted = 0; m_mis = 0; m_mis_addr = 0;
      return;
    end
    m_mis = 0;
    if (m_booting) begin
      m_booting = 0;
    end else if (m_halted) begin
      if (trap) begin m_pc = {trap_vector[31:2], 2'b00}; m_halted = 0; end
      else if (resume) m_halted = 0;
    end else begin
      if (trap) m_pc = {trap_vector[31:2], 2'b00};
      else if (br_taken) begin
        if (MIS_EN && br_target[1:0] != 2'b00) begin
          m_pc = {trap_vector[31:2], 2'b00}; m_mis = 1; m_mis_addr = br_target;
        end else m_pc = {br_target[31:2], 2'b00};
      end
      else if (halt) m_halted = 1;
      else if (!stall) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; trap = 0; halt = 0; resume = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; tick(); tick();
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    n_cmp++; if (pc_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
    n_cmp++; if (misalign !== 1'b0 || misalign_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mis got=%b/%h exp=0/0", misalign, misalign_addr); end
    rst_n = 1; tick();
    n_cmp++; if (pc_out !== 32'h0 || pc_valid !== 1'b1) begin n_bad++; $display("FAIL boot_run got=%h/%b exp=00000000/1", pc_out, pc_valid); end
    tick();
    n_cmp++; if (pc_out !== 32'h4) begin n_bad++; $display("FAIL inc1 got=%h exp=%h", pc_out, 32'h4); end
    tick();
    n_cmp++; if (pc_out !== 32'h8 || pc_seq !== 32'hC) begin n_bad++; $display("FAIL inc2 got=%h seq=%h exp=8/C", pc_out, pc_seq); end
  endtask

  task automatic test_wrap();
    idle_inputs();
    rst_n = 0; tick();
    n_cmp++; if (pc_out2 !== 32'hFFFF_FFF8 || pc_valid2 !== 1'b0) begin n_bad++; $display("FAIL wrap_reset got=%h/%b exp=fffffff8/0", pc_out2, pc_valid2); end
    rst_n = 1; tick();
    n_cmp++; if (pc_out2 !== 32'hFFFF_FFF8 || pc_valid2 !== 1'b1) begin n_bad++; $display("FAIL wrap_run got=%h/%b exp=fffffff8/1", pc_out2, pc_valid2); end
    tick();
    n_cmp++; if (pc_out2 !== 32'hFFFF_FFFC || pc_seq2 !== 32'h0) begin n_bad++; $display("FAIL wrap_fc got=%h seq=%h exp=fffffffc/0", pc_out2, pc_seq2); end
    tick();
    n_cmp++; if (pc_out2 !== 32'h0) begin n_bad++; $display("FAIL wrap_zero got=%h exp=0", pc_out2); end
  endtask

  task automatic test_stall_redirect();
    stall = 1; br_taken = 1; br_target = 32'h100; tick();
    n_cmp++; if (pc_out !== 32'h100) begin n_bad++; $display("FAIL stall_br got=%h exp=100", pc_out); end
    br_taken = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (pc_out !== 32'h100 || pc_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d got=%h/%b exp=100/1", i, pc_out, pc_valid); end
    end
    stall = 0; tick();
    n_cmp++; if (pc_out !== 32'h104) begin n_bad++; $display("FAIL stall_release got=%h exp=104", pc_out); end
  endtask

  task automatic test_trap_halt();
    trap = 1; trap_vector = 32'h80; br_taken = 1; br_target = 32'h200; tick();
    n_cmp++; if (pc_out !== 32'h80) begin n_bad++; $display("FAIL trap_over_br got=%h exp=80", pc_out); end
    idle_inputs(); halt = 1; tick();
    n_cmp++; if (pc_out !== 32'h84 - 32'h4 || pc_valid !== 1'b0) begin n_bad++; $display("FAIL halt got=%h/%b exp=80/0", pc_out, pc_valid); end
    halt = 0; br_taken = 1; br_target = 32'h300; stall = 1; tick();
    n_cmp++; if (pc_out !== 32'h80 || pc_valid !== 1'b0) begin n_bad++; $display("FAIL halted_ignore got=%h/%b exp=80/0", pc_out, pc_valid); end
    idle_inputs(); trap = 1; trap_vector = 32'h83; tick();
    n_cmp++; if (pc_out !== 32'h80 || pc_valid !== 1'b1) begin n_bad++; $display("FAIL halted_trap got=%h/%b exp=80/1", pc_out, pc_valid); end
    idle_inputs(); halt = 1; tick();
    halt = 1; resume = 1; tick();
    n_cmp++; if (pc_out !== 32'h80 || pc_valid !== 1'b1) begin n_bad++; $display("FAIL resume_wins got=%h/%b exp=80/1", pc_out, pc_valid); end
    idle_inputs(); tick();
    n_cmp++; if (pc_out !== 32'h84) begin n_bad++; $display("FAIL after_resume got=%h exp=84", pc_out); end
  endtask

  task automatic test_misalign();
    idle_inputs(); br_taken = 1; br_target = 32'h102; trap_vector = 32'h80; tick();
    br_taken = 0;
    if (MIS_EN) begin
      n_cmp++; if (pc_out !== 32'h80 || misalign !== 1'b1 || misalign_addr !== 32'h102) begin n_bad++; $display("FAIL mis_br got=%h/%b/%h exp=80/1/102", pc_out, misalign, misalign_addr); end
      tick();
      n_cmp++; if (misalign !== 1'b0 || misalign_addr !== 32'h102) begin n_bad++; $display("FAIL mis_pulse got=%b/%h exp=0/102", misalign, misalign_addr); end
      trap = 1; br_taken = 1; br_target = 32'h206; trap_vector = 32'h40; tick();
      idle_inputs();
      n_cmp++; if (pc_out !== 32'h40 || misalign !== 1'b0 || misalign_addr !== 32'h102) begin n_bad++; $display("FAIL mis_trap_wins got=%h/%b/%h exp=40/0/102", pc_out, misalign, misalign_addr); end
    end else begin
      n_cmp++; if (pc_out !== 32'h100 || misalign !== 1'b0 || misalign_addr !== 32'h0) begin n_bad++; $display("FAIL align_br got=%h/%b/%h exp=100/0/0", pc_out, misalign, misalign_addr); end
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs(); br_taken = 1; br_target = 32'h40; tick();
    idle_inputs(); halt = 1; tick();
    n_cmp++; if (pc_out !== 32'h40 || pc_valid !== 1'b0) begin n_bad++; $display("FAIL pre_rst got=%h/%b exp=40/0", pc_out, pc_valid); end
    halt = 0; trap = 1; trap_vector = 32'h500; rst_n = 0; tick();
    n_cmp++; if (pc_out !== 32'h0 || pc_valid !== 1'b0 || misalign !== 1'b0) begin n_bad++; $display("FAIL mid_rst got=%h/%b/%b exp=0/0/0", pc_out, pc_valid, misalign); end
    idle_inputs(); rst_n = 1; tick();
    n_cmp++; if (pc_out !== 32'h0 || pc_valid !== 1'b1) begin n_bad++; $display("FAIL mid_rst_boot got=%h/%b exp=0/1", pc_out, pc_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      trap      = ($urandom_range(0, 9) == 0);
      br_taken  = ($urandom_range(0, 3) == 0);
      halt      = ($urandom_range(0, 7) == 0);
      resume    = ($urandom_range(0, 3) == 0);
      stall     = ($urandom_range(0, 2) == 0);
      br_target = $urandom;
      if ($urandom_range(0, 1) == 0) br_target[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) br_target[31:4] = '1;
      trap_vector = $urandom;
      tick();
      n_cmp++; if (pc_out !== m_pc) begin n_bad++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, pc_out, m_pc); end
      n_cmp++; if (pc_valid !== (!m_booting && !m_halted)) begin n_bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, pc_valid, (!m_booting && !m_halted)); end
      n_cmp++; if (pc_seq !== m_pc + 32'd4) begin n_bad++; $display("FAIL rnd_seq[%0d] got=%h exp=%h", i, pc_seq, m_pc + 32'd4); end
      n_cmp++; if (misalign !== m_mis || misalign_addr !== m_mis_addr) begin n_bad++; $display("FAIL rnd_mis[%0d] got=%b/%h exp=%b/%h", i, misalign, misalign_addr, m_mis, m_mis_addr); end
    end
    idle_inputs(); rst_n = 1;
  endtask

  initial begin
    m_pc = 0; m_booting = 1; m_halted = 0; m_mis = 0; m_mis_addr = 0;
    test_reset();
    test_wrap();
    test_stall_redirect();
    test_trap_halt();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
